// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline definitions for the hazard/forwarding controller:
//   - operand-select codes driven to the ID-stage forwarding muxes
//   - encoding of the multi-cycle divider sequencer states
//   - default divider latency and a helper for the counter width
// No ports (package).
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Operand-select codes for the ID forwarding muxes
  localparam logic [1:0] FWD_RF       = 2'b00;  // value read from the regfile
  localparam logic [1:0] FWD_EX_ALU   = 2'b01;  // ALU result currently in EX
  localparam logic [1:0] FWD_MEM_ALU  = 2'b10;  // ALU result currently in MEM
  localparam logic [1:0] FWD_MEM_LOAD = 2'b11;  // load data currently in MEM

  // Divider sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Cycles the divider stays busy after a start
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  // Counter width: clog2 of the latency, but never a zero-width vector
  function automatic int unsigned div_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_div_sequencer.sv
// ----------------------------------------------------------------------------
// div_sequencer
// Tracks the multi-cycle divider: IDLE -> BUSY (DIV_CYCLES cycles) -> DONE
// (one cycle, HI/LO write strobe) -> IDLE.  A start is accepted only in IDLE
// and only when the pipeline is not stalled, so exactly DIV_CYCLES+1 cycles
// separate div_start_o from hilo_we_o.
// Ports:
//   clk          in   clock, rising edge
//   reset_i      in   synchronous active-high reset; also masks the outputs
//   start_req_i  in   a DIV/DIVU sits in ID
//   stall_i      in   pipeline stall; blocks the start
//   div_start_o  out  one-cycle start pulse to the divider
//   div_busy_o   out  sequencer is not IDLE
//   hilo_we_o    out  one-cycle HI/LO write strobe on completion
// ----------------------------------------------------------------------------
module div_sequencer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_i,
  input  logic start_req_i,
  input  logic stall_i,
  output logic div_start_o,
  output logic div_busy_o,
  output logic hilo_we_o
);

  localparam int unsigned CNT_W = div_cnt_width(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_start_o = 1'b0;
    hilo_we_o   = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start_req_i && !stall_i) begin
          div_start_o = 1'b1;
          state_d     = DIV_BUSY;
          cnt_d       = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        // The counter stops at zero; the zero cycle is the last busy one.
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DIV_DONE: begin
        hilo_we_o = 1'b1;
        state_d   = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase

    // While reset is high nothing may leak to the divider or HI/LO, even if
    // the registered state is still mid-divide.
    if (reset_i) begin
      div_start_o = 1'b0;
      hilo_we_o   = 1'b0;
    end
  end

  assign div_busy_o = (state_q != DIV_IDLE) && !reset_i;

endmodule : div_sequencer

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard detection and operand forwarding for a 5-stage pipeline with
// branches resolved in ID and a multi-cycle divider writing HI/LO.
// Ports:
//   clk, reset                   clock / synchronous active-high reset
//   id_rs, id_rt                 source fields of the ID instruction
//   id_use_rs, id_use_rt         ID instruction reads rs / rt
//   id_is_branch                 ID instruction compares rs/rt in ID
//   id_is_div                    ID instruction is DIV/DIVU
//   id_uses_hilo                 ID instruction touches HI/LO (incl. div)
//   ex_wreg, ex_m2reg, ex_rn     EX writes regfile / is a load / dest reg
//   mem_wreg, mem_m2reg, mem_rn  same for MEM
//   fwda, fwdb                   forwarding select codes for rs / rt
//   stall                        hold PC and IF/ID, bubble into ID/EX
//   div_start                    one-cycle divider start pulse
//   div_busy                     divider sequencer not IDLE
//   hilo_we                      one-cycle HI/LO write strobe
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_branch,
  input  logic       id_is_div,
  input  logic       id_uses_hilo,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       stall,
  output logic       div_start,
  output logic       div_busy,
  output logic       hilo_we
);

  // Destination matches; r0 is hard-wired to zero and never matches.
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

  assign ex_hit_rs  = (ex_rn  != 5'd0) && (ex_rn  == id_rs);
  assign ex_hit_rt  = (ex_rn  != 5'd0) && (ex_rn  == id_rt);
  assign mem_hit_rs = (mem_rn != 5'd0) && (mem_rn == id_rs);
  assign mem_hit_rt = (mem_rn != 5'd0) && (mem_rn == id_rt);

  // Forwarding: the younger EX ALU result wins over anything in MEM.  A load
  // in EX cannot be forwarded; that case is covered by the load-use stall.
  always_comb begin
    fwda = FWD_RF;
    if (id_use_rs && ex_wreg && !ex_m2reg && ex_hit_rs) begin
      fwda = FWD_EX_ALU;
    end else if (mem_wreg && mem_hit_rs) begin
      fwda = mem_m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
  end

  always_comb begin
    fwdb = FWD_RF;
    if (id_use_rt && ex_wreg && !ex_m2reg && ex_hit_rt) begin
      fwdb = FWD_EX_ALU;
    end else if (mem_wreg && mem_hit_rt) begin
      fwdb = mem_m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
  end

  // Hazards
  logic load_use_hz, branch_hz, hilo_hz;

  assign load_use_hz = ex_wreg && ex_m2reg &&
                       ((id_use_rs && ex_hit_rs) || (id_use_rt && ex_hit_rt));

  // Branches compare in ID, so any EX result is too late to forward, and a
  // load in MEM only has its data at the end of the cycle.
  assign branch_hz = id_is_branch &&
                     ((ex_wreg   && (ex_hit_rs  || ex_hit_rt)) ||
                      (mem_m2reg && (mem_hit_rs || mem_hit_rt)));

  // div_busy is already masked during reset, which disables this hazard too.
  assign hilo_hz = id_uses_hilo && div_busy;

  assign stall = load_use_hz || branch_hz || hilo_hz;

  div_sequencer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk         (clk),
    .reset_i     (reset),
    .start_req_i (id_is_div),
    .stall_i     (stall),
    .div_start_o (div_start),
    .div_busy_o  (div_busy),
    .hilo_we_o   (hilo_we)
  );

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt, id_is_branch, id_is_div, id_uses_hilo;
  logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [4:0] ex_rn, mem_rn;
  logic [1:0] fwda, fwdb;
  logic       stall, div_start, div_busy, hilo_we;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_is_div    (id_is_div),
    .id_uses_hilo (id_uses_hilo),
    .ex_wreg      (ex_wreg),
    .ex_m2reg     (ex_m2reg),
    .ex_rn        (ex_rn),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_rn       (mem_rn),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .stall        (stall),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .hilo_we      (hilo_we)
  );

  task automatic drive_idle;
    id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_is_branch = 1'b0; id_is_div = 1'b0; id_uses_hilo = 1'b0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0;
    mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_rn = 5'd0;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1'b1;
    id_is_div = 1'b1;
    id_uses_hilo = 1'b1;
    tick();
    tick();
    #1;
    tests_run++;
    if ({div_start, div_busy, hilo_we, stall} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got start/busy/we/stall=%b expected 0000",
               {div_start, div_busy, hilo_we, stall});
    end
    drive_idle();
    reset = 1'b0;
    tick();
    #1;
    tests_run++;
    if (div_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_after: got div_busy=%b expected 0", div_busy);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fwd_ex;
    drive_idle();
    ex_wreg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    tests_run++;
    if (fwda !== 2'b01 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_ex_r5: got fwda=%b stall=%b expected 01 0", fwda, stall);
    end
    ex_rn = 5'd0; id_rs = 5'd0;
    #1;
    tests_run++;
    if (fwda !== 2'b00 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_ex_r0: got fwda=%b stall=%b expected 00 0", fwda, stall);
    end
    // operand not used -> no EX forwarding
    ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
    #1;
    tests_run++;
    if (fwda !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_ex_unused: got fwda=%b expected 00", fwda);
    end
    // MEM ALU result on rt
    drive_idle();
    mem_wreg = 1'b1; mem_rn = 5'd12; id_rt = 5'd12; id_use_rt = 1'b1;
    #1;
    tests_run++;
    if (fwdb !== 2'b10 || fwda !== 2'b00 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_mem_alu_rt: got fwdb=%b fwda=%b stall=%b expected 10 00 0",
               fwdb, fwda, stall);
    end
    $display("[TB] test_fwd_ex done");
  endtask

  task automatic test_load_use;
    tick();
    drive_idle();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd7;
    id_rt = 5'd7; id_use_rt = 1'b1; id_rs = 5'd2; id_use_rs = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b1 || fwdb !== 2'b00) begin
      tests_failed++;
      $display("FAIL load_use_stall: got stall=%b fwdb=%b expected 1 00", stall, fwdb);
    end
    // bubble in EX, load moved to MEM
    tick();
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0;
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd7;
    #1;
    tests_run++;
    if (stall !== 1'b0 || fwdb !== 2'b11) begin
      tests_failed++;
      $display("FAIL load_use_mem: got stall=%b fwdb=%b expected 0 11", stall, fwdb);
    end
    // load to r0 never stalls
    drive_idle();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_r0: got stall=%b expected 0", stall);
    end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_ex_priority;
    drive_idle();
    ex_wreg = 1'b1; ex_rn = 5'd3;
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd3;
    id_rs = 5'd3; id_use_rs = 1'b1;
    #1;
    tests_run++;
    if (fwda !== 2'b01 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL ex_priority: got fwda=%b stall=%b expected 01 0", fwda, stall);
    end
    $display("[TB] test_ex_priority done");
  endtask

  task automatic test_branch;
    drive_idle();
    id_is_branch = 1'b1; id_rs = 5'd4; id_rt = 5'd9; id_use_rs = 1'b1; id_use_rt = 1'b1;
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rn = 5'd4;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_mem_load: got stall=%b expected 1", stall);
    end
    mem_m2reg = 1'b0;
    #1;
    tests_run++;
    if (fwda !== 2'b10 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_mem_alu: got fwda=%b stall=%b expected 10 0", fwda, stall);
    end
    // ALU result still in EX on rt -> must stall
    mem_wreg = 1'b0; mem_rn = 5'd0;
    ex_wreg = 1'b1; ex_rn = 5'd9;
    #1;
    tests_run++;
    if (stall !== 1'b1 || fwdb !== 2'b01) begin
      tests_failed++;
      $display("FAIL branch_ex_alu: got stall=%b fwdb=%b expected 1 01", stall, fwdb);
    end
    // same EX write seen by a non-branch -> no stall
    id_is_branch = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL nonbranch_ex_alu: got stall=%b expected 0", stall);
    end
    $display("[TB] test_branch done");
  endtask

  task automatic test_div;
    logic [3:0] exp_v;
    tick();
    drive_idle();
    id_is_div = 1'b1; id_uses_hilo = 1'b1;
    #1;
    tests_run++;
    if ({div_start, div_busy, hilo_we, stall} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL div_c0: got start/busy/we/stall=%b expected 1000",
               {div_start, div_busy, hilo_we, stall});
    end
    for (int c = 1; c <= 35; c++) begin
      tick();
      id_is_div = 1'b0;
      id_uses_hilo = (c >= 5 && c <= 34);   // mfhi from cycle 5
      #1;
      exp_v = {1'b0, (c <= 33), (c == 33), (c >= 5 && c <= 33)};
      tests_run++;
      if ({div_start, div_busy, hilo_we, stall} !== exp_v) begin
        tests_failed++;
        $display("FAIL div_c%0d: got start/busy/we/stall=%b expected %b",
                 c, {div_start, div_busy, hilo_we, stall}, exp_v);
      end
    end
    $display("[TB] test_div done");
  endtask

  task automatic test_reset_mid_div;
    int we_cnt;
    int we_cyc;
    tick();
    drive_idle();
    id_is_div = 1'b1; id_uses_hilo = 1'b1;
    #1;
    tests_run++;
    if (div_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_div_start: got div_start=%b expected 1", div_start);
    end
    for (int c = 1; c <= 9; c++) begin
      tick();
      drive_idle();
    end
    tick();   // cycle 10
    reset = 1'b1;
    id_uses_hilo = 1'b1;
    ex_wreg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    tests_run++;
    if (div_busy !== 1'b0 || stall !== 1'b0 || fwda !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_during: got busy=%b stall=%b fwda=%b expected 0 0 01",
               div_busy, stall, fwda);
    end
    tick();
    reset = 1'b0;
    drive_idle();
    #1;
    tests_run++;
    if (div_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_idle_next: got div_busy=%b expected 0", div_busy);
    end
    we_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (hilo_we === 1'b1) we_cnt++;
      tick();
    end
    tests_run++;
    if (we_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_hilo_we: got %0d strobes expected 0", we_cnt);
    end
    // a following div runs normally
    id_is_div = 1'b1; id_uses_hilo = 1'b1;
    #1;
    tests_run++;
    if (div_start !== 1'b1 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_new_start: got start=%b stall=%b expected 1 0", div_start, stall);
    end
    we_cnt = 0;
    we_cyc = -1;
    for (int c = 1; c <= 36; c++) begin
      tick();
      drive_idle();
      #1;
      if (hilo_we === 1'b1) begin
        we_cnt++;
        we_cyc = c;
      end
    end
    tests_run++;
    if (we_cnt !== 1 || we_cyc !== 33) begin
      tests_failed++;
      $display("FAIL rst_new_done: got %0d strobes at cycle %0d expected 1 at 33",
               we_cnt, we_cyc);
    end
    $display("[TB] test_reset_mid_div done");
  endtask

  task automatic test_back_to_back;
    tick();
    drive_idle();
    id_is_div = 1'b1; id_uses_hilo = 1'b1;
    #1;
    tests_run++;
    if (div_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first_start: got div_start=%b expected 1", div_start);
    end
    for (int c = 1; c <= 32; c++) begin
      tick();
      drive_idle();
    end
    tick();   // cycle 33: DONE, second div waiting in ID
    id_is_div = 1'b1; id_uses_hilo = 1'b1;
    #1;
    tests_run++;
    if ({div_start, div_busy, hilo_we, stall} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL b2b_done: got start/busy/we/stall=%b expected 0111",
               {div_start, div_busy, hilo_we, stall});
    end
    tick();   // cycle 34: first IDLE cycle
    #1;
    tests_run++;
    if ({div_start, div_busy, hilo_we, stall} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL b2b_restart: got start/busy/we/stall=%b expected 1000",
               {div_start, div_busy, hilo_we, stall});
    end
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (div_busy !== 1'b1 || div_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_busy: got busy=%b start=%b expected 1 0", div_busy, div_start);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_ex_priority();
    test_branch();
    test_div();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
